// File: rtl/decoder_seq.sv
// N-to-2**N registered decoder with a direct-address mode, a divided scan
// sequencer that can be frozen and resumed, and a combinational output enable.
module decoder_seq #(
  parameter int N          = 2,
  parameter int SCAN_DIV   = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              a_valid,
  input  logic [N-1:0]      a,
  output logic              a_ready,
  output logic [2**N-1:0]   d,
  output logic              d_valid,
  output logic              scan_wrap
);
  localparam int M = 2**N;
  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN, HOLD} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [7:0]   div_q, div_d;
  logic         vld_q, vld_d;
  logic         wrap_q, wrap_d;
  logic [M-1:0] raw;

  assign a_ready   = (mode == 2'b00) & ~rst;
  assign d_valid   = vld_q;
  assign scan_wrap = wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;
    case (mode)
      2'b00: begin
        if (a_valid) begin
          state_d = DIRECT;
          idx_d   = a;
          div_d   = '0;
          vld_d   = 1'b1;
        end else if (state_q == SCAN || state_q == HOLD) begin
          state_d = vld_q ? DIRECT : IDLE;
        end
      end
      2'b01: begin
        state_d = SCAN;
        // A hold that interrupted a live line resumes; anything else starts over.
        if (state_q == SCAN || (state_q == HOLD && vld_q)) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == '1);
          end else begin
            div_d = div_q + 8'd1;
          end
        end else begin
          idx_d = '0;
          div_d = '0;
          vld_d = 1'b1;
        end
      end
      2'b10: state_d = HOLD;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        div_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    raw = '0;
    if (vld_q) raw[idx_q] = 1'b1;
    if (!en)             d = ACTIVE_LOW ? '1 : '0;
    else if (ACTIVE_LOW) d = ~raw;
    else                 d = raw;
  end

endmodule
